// File: rtl/tbu_pkg.sv
// tbu_pkg: shared types and helpers for the Viterbi traceback unit (tbu_gen).
// Holds the FSM state encoding, trellis size derivation and the
// predecessor-state step used while walking the survivor path backwards.
package tbu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_UPDATE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } tbu_state_t;

    // Widest state register supported (constraint length up to 9).
    localparam int MAX_SW = 8;

    function automatic int calc_sw(input int k);
        return k - 1;
    endfunction

    function automatic int calc_num_states(input int k);
        return 1 << (k - 1);
    endfunction

    // One traceback step: shift the stored decision bit in at the LSB and
    // keep only the low sw bits of the state.
    function automatic logic [MAX_SW-1:0] pred_state(input logic [MAX_SW-1:0] s,
                                                     input logic             d,
                                                     input int               sw);
        logic [MAX_SW-1:0] mask;
        mask = MAX_SW'((1 << sw) - 1);
        return ((s << 1) | {{(MAX_SW-1){1'b0}}, d}) & mask;
    endfunction

endpackage

// File: rtl/tbu_lifo.sv
// tbu_lifo: small bit-wide last-in/first-out buffer used to put traceback
// bits back into chronological order. top shows the most recently pushed
// bit; pushes while full and pops while empty are ignored.
module tbu_lifo #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          push_bit,
    input  logic          pop,
    output logic          top,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] mem;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;

    assign wr_idx = IW'(count);
    assign rd_idx = IW'(count - CW'(1));
    assign top    = (count != '0) ? mem[rd_idx] : 1'b0;

    // Storage and fill level; clear only needs to forget the fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && (count != CW'(DEPTH))) begin
            mem[wr_idx] <= push_bit;
            count       <= count + CW'(1);
        end else if (pop && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/tbu_gen.sv
// tbu_gen: Viterbi traceback unit. Starting from a given trellis state and
// decision-memory address, it walks TB_DEPTH steps backwards through the
// stored decision words and emits the last OUT_LEN decoded bits through a
// valid/ready handshake.
// Build option: define TBU_GEN_LIFO_EN to buffer the emitted bits in a LIFO
// and present them in chronological order; without it bits leave in
// traceback (reverse-chronological) order as they are decoded.
module tbu_gen
    import tbu_pkg::*;
#(
    parameter  int K          = 4,
    parameter  int TB_DEPTH   = 16,
    parameter  int OUT_LEN    = 8,
    parameter  int MEM_DEPTH  = 64,
    localparam int SW         = calc_sw(K),
    localparam int NUM_STATES = calc_num_states(K),
    localparam int AW         = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SW-1:0]         start_state,
    input  logic [AW-1:0]         start_addr,
    input  logic                  abort,
    output logic                  dec_rd_en,
    output logic [AW-1:0]         dec_addr,
    input  logic [NUM_STATES-1:0] dec_data,
    output logic                  bit_out,
    output logic                  bit_valid,
    input  logic                  bit_ready,
    output logic                  busy,
    output logic                  done
);

    // Step counter is wide enough to hold TB_DEPTH itself.
    localparam int             STW        = $clog2(TB_DEPTH + 1);
    localparam logic [STW-1:0] SKIP_STEPS = STW'(TB_DEPTH - OUT_LEN);
    localparam logic [STW-1:0] LAST_STEP  = STW'(TB_DEPTH);

    tbu_state_t     state;
    tbu_state_t     state_nxt;
    logic [SW-1:0]  cur_state;
    logic [AW-1:0]  rd_addr;
    logic [STW-1:0] step;
    logic [STW-1:0] step_inc;
    logic           emits;
    logic           dec_bit;
    logic           handshake;

    assign step_inc  = step + STW'(1);
    assign emits     = (step >= SKIP_STEPS);
    assign dec_bit   = dec_data[cur_state];
    assign handshake = bit_valid && bit_ready;

`ifdef TBU_GEN_LIFO_EN
    localparam int CW = $clog2(OUT_LEN + 1);

    logic          lifo_push;
    logic          lifo_pop;
    logic          lifo_clear;
    logic          lifo_top;
    logic [CW-1:0] lifo_cnt;

    assign lifo_push  = (state == ST_UPDATE) && emits && !abort;
    assign lifo_pop   = (state == ST_DRAIN) && handshake && !abort;
    assign lifo_clear = ((state == ST_IDLE) && start) || abort;

    tbu_lifo #(
        .DEPTH (OUT_LEN)
    ) u_lifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (lifo_clear),
        .push     (lifo_push),
        .push_bit (cur_state[SW-1]),
        .pop      (lifo_pop),
        .top      (lifo_top),
        .count    (lifo_cnt)
    );
`else
    logic bit_r;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_READ;
            ST_READ:   state_nxt = ST_UPDATE;
`ifdef TBU_GEN_LIFO_EN
            ST_UPDATE: state_nxt = (step_inc < LAST_STEP) ? ST_READ : ST_DRAIN;
            ST_DRAIN:  if (bit_ready && (lifo_cnt <= CW'(1))) state_nxt = ST_DONE;
`else
            ST_UPDATE: begin
                if (emits) begin
                    state_nxt = ST_EMIT;
                end else begin
                    state_nxt = (step_inc < LAST_STEP) ? ST_READ : ST_DONE;
                end
            end
            ST_EMIT:   if (bit_ready) state_nxt = (step < LAST_STEP) ? ST_READ : ST_DONE;
`endif
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        dec_rd_en = 1'b0;
        dec_addr  = '0;
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        case (state)
            ST_READ: begin
                dec_rd_en = 1'b1;
                dec_addr  = rd_addr;
            end
`ifdef TBU_GEN_LIFO_EN
            ST_DRAIN: begin
                bit_valid = 1'b1;
                bit_out   = lifo_top;
            end
`else
            ST_EMIT: begin
                bit_valid = 1'b1;
                bit_out   = bit_r;
            end
`endif
            default: ;
        endcase
    end

    // Traceback datapath: latch the start point, then one trellis step per UPDATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= '0;
            rd_addr   <= '0;
            step      <= '0;
`ifndef TBU_GEN_LIFO_EN
            bit_r     <= 1'b0;
`endif
        end else if ((state == ST_IDLE) && start) begin
            cur_state <= start_state;
            rd_addr   <= start_addr;
            step      <= '0;
        end else if ((state == ST_UPDATE) && !abort) begin
            // MEM_DEPTH is a power of two, so the AW-bit decrement wraps 0 to MEM_DEPTH-1.
            cur_state <= SW'(pred_state(MAX_SW'(cur_state), dec_bit, SW));
            rd_addr   <= rd_addr - AW'(1);
            step      <= step_inc;
`ifndef TBU_GEN_LIFO_EN
            bit_r     <= cur_state[SW-1];
`endif
        end
    end

endmodule

// File: tb/tb_tbu_gen.sv
// tb_tbu_gen: directed and randomized checks of tbu_gen against a
// behavioural traceback model (K=4, TB_DEPTH=8, OUT_LEN=4, MEM_DEPTH=16).
module tb_tbu_gen;

    localparam int K         = 4;
    localparam int TB_DEPTH  = 8;
    localparam int OUT_LEN   = 4;
    localparam int MEM_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] start_state;
    logic [3:0] start_addr;
    logic       abort;
    logic       dec_rd_en;
    logic [3:0] dec_addr;
    logic [7:0] dec_data = '0;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [MEM_DEPTH];
    logic       exp_tb [OUT_LEN];
    logic [3:0] exp_addr [TB_DEPTH];

    tbu_gen #(
        .K         (K),
        .TB_DEPTH  (TB_DEPTH),
        .OUT_LEN   (OUT_LEN),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_state (start_state),
        .start_addr  (start_addr),
        .abort       (abort),
        .dec_rd_en   (dec_rd_en),
        .dec_addr    (dec_addr),
        .dec_data    (dec_data),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Decision memory with one cycle read latency.
    always @(posedge clk) begin
        if (dec_rd_en) dec_data <= mem[dec_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk the trellis backwards with integer arithmetic.
    function automatic void model(input logic [2:0] ss, input logic [3:0] sa);
        int s = int'(ss);
        int a = int'(sa);
        for (int i = 0; i < TB_DEPTH; i++) begin
            exp_addr[i] = 4'(a);
            if (i >= TB_DEPTH - OUT_LEN) exp_tb[i - (TB_DEPTH - OUT_LEN)] = (s >= 4);
            s = (s * 2 + int'(mem[a][s])) % 8;
            a = (a + MEM_DEPTH - 1) % MEM_DEPTH;
        end
    endfunction

    function automatic logic exp_out(input int j);
`ifdef TBU_GEN_LIFO_EN
        return exp_tb[OUT_LEN - 1 - j];
`else
        return exp_tb[j];
`endif
    endfunction

    task automatic fill_mem(input int kind);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            case (kind)
                0:       mem[i] = 8'h00;
                1:       mem[i] = 8'hFF;
                default: mem[i] = 8'($urandom);
            endcase
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: stall the first bit 5 cycles
    task automatic run(input string tag, input logic [2:0] ss, input logic [3:0] sa,
                       input int mode, input bit poke);
        int   nbits = 0;
        int   nrd   = 0;
        int   dones = 0;
        int   stall = 0;
        bit   fin   = 1'b0;
        logic held  = 1'b0;
        model(ss, sa);
        @(negedge clk);
        start_state = ss;
        start_addr  = sa;
        start       = 1'b1;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            start = poke && (cyc == 5);
            if (dec_rd_en) begin
                if (nrd < TB_DEPTH) check({tag, ":addr"}, 32'(dec_addr), 32'(exp_addr[nrd]));
                nrd++;
            end
            if (mode == 0) begin
                bit_ready = 1'b1;
            end else if (mode == 1) begin
                bit_ready = 1'($urandom_range(0, 1));
            end else if (stall > 0 && stall < 5) begin
                check({tag, ":stall_valid"}, 32'(bit_valid), 32'd1);
                check({tag, ":stall_bit"}, 32'(bit_out), 32'(held));
                bit_ready = 1'b0;
                stall++;
            end else if (stall == 0 && bit_valid) begin
                held      = bit_out;
                bit_ready = 1'b0;
                stall     = 1;
            end else begin
                bit_ready = 1'b1;
            end
            if (bit_valid && bit_ready) begin
                if (nbits < OUT_LEN) check({tag, ":bit"}, 32'(bit_out), 32'(exp_out(nbits)));
                nbits++;
            end
            if (done) begin
                dones++;
                fin = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, ":finished"}, 32'(fin), 32'd1);
        check({tag, ":done_cnt"}, 32'(dones), 32'd1);
        check({tag, ":nbits"}, 32'(nbits), 32'(OUT_LEN));
        check({tag, ":nreads"}, 32'(nrd), 32'(TB_DEPTH));
        @(negedge clk);
        check({tag, ":busy_after"}, 32'(busy), 32'd0);
        check({tag, ":done_pulse"}, 32'(done), 32'd0);
        bit_ready = 1'b0;
    endtask

    initial begin
        int  nrd;
        int  dones;
        bit  aborted;

        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        bit_ready   = 1'b0;
        start_state = '0;
        start_addr  = '0;
        fill_mem(0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:bit_valid", 32'(bit_valid), 32'd0);
        check("rst:bit_out", 32'(bit_out), 32'd0);
        check("rst:dec_rd_en", 32'(dec_rd_en), 32'd0);
        check("rst:dec_addr", 32'(dec_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero decisions from state 0
        fill_mem(0);
        run("zero", 3'd0, 4'd0, 0, 1'b0);

        // All-ones decisions from state 7: state stays 7
        fill_mem(1);
        run("ones", 3'd7, 4'd5, 0, 1'b0);

        // Address wrap from 2, with start poked while busy
        fill_mem(2);
        run("addr_wrap", 3'($urandom), 4'd2, 0, 1'b1);
        check("addr_wrap:a3", 32'(exp_addr[3]), 32'd15);

        // Stall the first bit
        fill_mem(2);
        run("stall", 3'($urandom), 4'($urandom), 2, 1'b0);

        // Asymmetric traceback-order bits 1,1,0,0
        fill_mem(0);
        mem[14] = 8'hFF;
        mem[13] = 8'hFF;
        run("asym", 3'd0, 4'd15, 0, 1'b0);
        check("asym:tb_order", {28'd0, exp_tb[0], exp_tb[1], exp_tb[2], exp_tb[3]}, 32'b1100);

        // Randomized runs with random backpressure
        for (int r = 0; r < 6; r++) begin
            fill_mem(2);
            run("rand", 3'($urandom), 4'($urandom), 1, 1'($urandom_range(0, 1)));
        end

        // Abort at step 3
        fill_mem(2);
        bit_ready = 1'b1;
        @(negedge clk);
        start_state = 3'($urandom);
        start_addr  = 4'($urandom);
        start       = 1'b1;
        nrd         = 0;
        aborted     = 1'b0;
        for (int c = 0; c < 100 && !aborted; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (dec_rd_en) begin
                nrd++;
                if (nrd == 4) begin
                    abort   = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
        check("abort:reached", 32'(aborted), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:bit_valid", 32'(bit_valid), 32'd0);
        check("abort:dec_rd_en", 32'(dec_rd_en), 32'd0);
        dones = 0;
        nrd   = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (dec_rd_en) nrd++;
        end
        check("abort:no_done", 32'(dones), 32'd0);
        check("abort:no_reads", 32'(nrd), 32'd0);

        // Reset mid-run, then a clean run
        fill_mem(2);
        @(negedge clk);
        start_state = 3'($urandom);
        start_addr  = 4'($urandom);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst:busy", 32'(busy), 32'd0);
        check("midrst:bit_valid", 32'(bit_valid), 32'd0);
        check("midrst:dec_rd_en", 32'(dec_rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("after_rst", 3'($urandom), 4'($urandom), 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
